// File: rtl/ref_bank_mem_pkg.sv
// Shared motion-estimation memory package.
// Holds the reference line bank geometry and the read lane rotation step.
// The memory controller and ref_bank_mem both import these values.
package ref_bank_mem_pkg;

  localparam int ME_NUM_BANK    = 32;  // reference line banks
  localparam int ME_DEPTH       = 96;  // lines per bank
  localparam int ME_AW          = 7;   // per-bank line address width
  localparam int ME_PW          = 8;   // pixel width
  localparam int ME_ROT_STEP    = 4;   // lanes skipped per rotation select step
  localparam int ME_ROT_SEL_MAX = 8;   // rotation selects 0..ME_ROT_SEL_MAX-1 are legal

  // Bank feeding output lane 'lane' for rotation select 'sel'.
  function automatic int rot_src(input int lane, input int sel, input int num_bank);
    return (lane + ME_ROT_STEP * sel) % num_bank;
  endfunction

endpackage

// File: rtl/ref_line_bank.sv
// One reference line bank: DEPTH x PW storage, one write port and one
// synchronous read port. A read and a write to the same line on the same
// edge return the old contents (read-first).
// Ports:
//   clk           clock
//   we/waddr/wdata  write port; caller guarantees waddr < DEPTH when we=1
//   re/raddr      read enable and line address; caller guarantees raddr < DEPTH when re=1
//   rdata         registered read data, holds when re=0
// Storage is not reset.
module ref_line_bank
  import ref_bank_mem_pkg::*;
#(
  parameter int DEPTH = ME_DEPTH,
  parameter int AW    = ME_AW,
  parameter int PW    = ME_PW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [PW-1:0] rdata
);

  logic [PW-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ref_bank_mem.sv
// Reference line memory: NUM_BANK independent line banks with per-bank
// writes and a common-address rotated line read.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   Bank_sel            per-bank write enable
//   write_address_all   per-bank write line address, bank i at [i*AW +: AW]
//   wr_data             per-bank write pixel, bank i at [i*PW +: PW]
//   rd_address          common read line address
//   rd8R_en             read request, active-low
//   rdR_sel             lane rotation select, 0..7 legal
//   rd_data             rotated line, lane j = bank (j + 4*rdR_sel) mod NUM_BANK
//   rd_valid            rd_data updated this cycle (2 cycles after request)
//   err, err_clr        sticky error flag and its synchronous clear
module ref_bank_mem
  import ref_bank_mem_pkg::*;
#(
  parameter int NUM_BANK = ME_NUM_BANK,
  parameter int DEPTH    = ME_DEPTH,
  parameter int AW       = ME_AW,
  parameter int PW       = ME_PW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BANK-1:0]    Bank_sel,
  input  logic [NUM_BANK*AW-1:0] write_address_all,
  input  logic [NUM_BANK*PW-1:0] wr_data,
  input  logic [AW-1:0]          rd_address,
  input  logic                   rd8R_en,
  input  logic [3:0]             rdR_sel,
  output logic [NUM_BANK*PW-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   err,
  input  logic                   err_clr
);

  localparam int          BW      = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [3:0]  SEL_LIM = 4'(ME_ROT_SEL_MAX);

  logic [NUM_BANK-1:0]    wr_ok;
  logic [NUM_BANK-1:0]    wr_bad;
  logic [PW-1:0]          bank_q [NUM_BANK];
  logic                   rd_acc;
  logic                   rd_addr_ok;
  logic                   rd_sel_ok;
  logic                   rd_bank_en;
  logic                   err_set;
  logic                   s1_valid;
  logic                   s1_zero;
  logic [3:0]             s1_sel;
  logic [NUM_BANK*PW-1:0] rot_line;
  logic [BW-1:0]          src;

  assign rd_acc     = ~rd8R_en;
  assign rd_addr_ok = {1'b0, rd_address} < DEPTH_L;
  assign rd_sel_ok  = rdR_sel < SEL_LIM;
  // Out-of-range addresses never reach the array; the zero result comes from s1_zero.
  assign rd_bank_en = rd_acc & rd_addr_ok;

  for (genvar i = 0; i < NUM_BANK; i++) begin : g_bank
    logic [AW-1:0] waddr;
    logic          waddr_ok;

    assign waddr    = write_address_all[i*AW +: AW];
    assign waddr_ok = {1'b0, waddr} < DEPTH_L;
    assign wr_ok[i]  = Bank_sel[i] & waddr_ok;
    assign wr_bad[i] = Bank_sel[i] & ~waddr_ok;

    ref_line_bank #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .PW    (PW)
    ) u_bank (
      .clk   (clk),
      .we    (wr_ok[i]),
      .waddr (waddr),
      .wdata (wr_data[i*PW +: PW]),
      .re    (rd_bank_en),
      .raddr (rd_address),
      .rdata (bank_q[i])
    );
  end

  assign err_set = (|wr_bad) | (rd_acc & ~(rd_addr_ok & rd_sel_ok));

  // Stage 1: the array read is in flight; remember how to finish it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_sel   <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_zero <= ~(rd_addr_ok & rd_sel_ok);
        s1_sel  <= rdR_sel;
      end
    end
  end

  always_comb begin
    rot_line = '0;
    src      = '0;
    for (int j = 0; j < NUM_BANK; j++) begin
      src = BW'(rot_src(j, int'(s1_sel), NUM_BANK));
      rot_line[j*PW +: PW] = bank_q[src];
    end
  end

  // Stage 2: rotate register; rd_data holds whenever no read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else begin
      rd_valid <= s1_valid;
      if (s1_valid) rd_data <= s1_zero ? '0 : rot_line;
      // A new error in the clear cycle wins over err_clr.
      err <= err_set | (err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_ref_bank_mem.sv
// Directed and randomized bench for ref_bank_mem.
module tb_ref_bank_mem;
  import ref_bank_mem_pkg::*;

  localparam int NB    = ME_NUM_BANK;
  localparam int DEPTH = ME_DEPTH;
  localparam int AW    = ME_AW;
  localparam int PW    = ME_PW;
  localparam int W     = NB * PW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NB-1:0]    Bank_sel;
  logic [NB*AW-1:0] write_address_all;
  logic [W-1:0]     wr_data;
  logic [AW-1:0]    rd_address;
  logic             rd8R_en;
  logic [3:0]       rdR_sel;
  logic [W-1:0]     rd_data;
  logic             rd_valid;
  logic             err;
  logic             err_clr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] exp;
    logic [W-1:0] mask;
  } exp_t;

  exp_t          q[$];
  logic [PW-1:0] mdl   [NB][DEPTH];
  bit            known [NB][DEPTH];

  always #5 clk = ~clk;

  ref_bank_mem #(
    .NUM_BANK (NB),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .PW       (PW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Bank_sel          (Bank_sel),
    .write_address_all (write_address_all),
    .wr_data           (wr_data),
    .rd_address        (rd_address),
    .rd8R_en           (rd8R_en),
    .rdR_sel           (rdR_sel),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .err               (err),
    .err_clr           (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Bank_sel = '0;
    rd8R_en  = 1'b1;
    err_clr  = 1'b0;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_lane(input string tag, input int j, input logic [PW-1:0] exp);
    logic [PW-1:0] obs;
    obs = rd_data[j*PW +: PW];
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s lane %0d: observed=%h expected=%h", tag, j, obs, exp);
    end
  endtask

  task automatic wr_one(input int bank, input int addr, input logic [PW-1:0] data);
    Bank_sel = '0;
    Bank_sel[bank] = 1'b1;
    write_address_all[bank*AW +: AW] = AW'(addr);
    wr_data[bank*PW +: PW] = data;
    tick();
    Bank_sel = '0;
  endtask

  // Issue one read, check the 2-cycle latency, return at the rd_valid cycle.
  task automatic do_read(input string tag, input int addr, input int sel);
    rd8R_en    = 1'b0;
    rd_address = AW'(addr);
    rdR_sel    = 4'(sel);
    tick();
    rd8R_en = 1'b1;
    check_bit({tag, "_lat1"}, rd_valid, 1'b0);
    tick();
    check_bit({tag, "_valid"}, rd_valid, 1'b1);
  endtask

  task automatic take_output();
    exp_t e;
    if (rd_valid === 1'b1) begin
      if (q.size() == 0) begin
        check_bit("rand_extra_valid", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        check_bus("rand_data", rd_data & e.mask, e.exp);
      end
    end
  endtask

  initial begin
    exp_t e;
    int   n_valid;
    int   n_acc;
    logic err_m;
    logic set;

    rst_n             = 1'b0;
    write_address_all = '0;
    wr_data           = '0;
    rd_address        = '0;
    rdR_sel           = '0;
    idle();

    // Reset state
    tick();
    tick();
    check_bit("rst_valid", rd_valid, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check_bus("rst_data", rd_data, '0);
    rst_n = 1'b1;
    tick();

    // Banks 0..3 filled with pixel = line
    for (int line = 0; line < DEPTH; line++) begin
      Bank_sel = NB'(32'h0000_000F);
      for (int b = 0; b < 4; b++) begin
        write_address_all[b*AW +: AW] = AW'(line);
        wr_data[b*PW +: PW] = PW'(line);
      end
      tick();
    end
    Bank_sel = '0;
    do_read("fill_l5", 5, 0);
    for (int j = 0; j < 4; j++) check_lane("fill_l5", j, 8'd5);
    tick();
    check_bit("fill_l5_one_cycle", rd_valid, 1'b0);
    check_lane("fill_l5_hold", 0, 8'd5);

    // Bank i line 0 = i, read with rotation 1
    Bank_sel = '1;
    for (int b = 0; b < NB; b++) begin
      write_address_all[b*AW +: AW] = '0;
      wr_data[b*PW +: PW] = PW'(b);
    end
    tick();
    Bank_sel = '0;
    do_read("rot1", 0, 1);
    check_lane("rot1", 0, 8'd4);
    check_lane("rot1", 27, 8'd31);
    check_lane("rot1", 28, 8'd0);
    check_lane("rot1", 31, 8'd3);
    do_read("rot7", 0, 7);
    check_lane("rot7", 0, 8'd28);
    check_lane("rot7", 4, 8'd0);

    // Read-first on a same-cycle write
    wr_one(2, 10, 8'hAA);
    Bank_sel    = '0;
    Bank_sel[2] = 1'b1;
    write_address_all[2*AW +: AW] = AW'(10);
    wr_data[2*PW +: PW] = 8'h55;
    rd8R_en    = 1'b0;
    rd_address = AW'(10);
    rdR_sel    = 4'd0;
    tick();
    Bank_sel = '0;
    rd8R_en  = 1'b1;
    tick();
    check_bit("rf_valid", rd_valid, 1'b1);
    check_lane("rf_old", 2, 8'hAA);
    do_read("rf_new", 10, 0);
    check_lane("rf_new", 2, 8'h55);

    // Error handling
    check_bit("err_idle", err, 1'b0);
    Bank_sel    = '0;
    Bank_sel[7] = 1'b1;
    Bank_sel[6] = 1'b1;
    write_address_all[7*AW +: AW] = AW'(96);
    wr_data[7*PW +: PW] = 8'hEE;
    write_address_all[6*AW +: AW] = AW'(20);
    wr_data[6*PW +: PW] = 8'h66;
    tick();
    Bank_sel = '0;
    check_bit("err_bad_wr", err, 1'b1);
    tick();
    check_bit("err_sticky", err, 1'b1);
    do_read("bad_wr_b7", 0, 1);
    check_lane("bad_wr_b7", 3, 8'd7);
    do_read("bad_wr_b6", 20, 1);
    check_lane("bad_wr_b6", 2, 8'h66);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_bit("err_clr", err, 1'b0);
    do_read("sel9", 0, 9);
    check_bus("sel9_zero", rd_data, '0);
    check_bit("sel9_err", err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    do_read("rd_a100", 5, 0);
    check_lane("rd_a5", 1, 8'd5);
    check_bit("rd_a5_err", err, 1'b0);
    do_read("rd_a100", 100, 0);
    check_bus("rd_a100_zero", rd_data, '0);
    check_bit("rd_a100_err", err, 1'b1);
    err_clr = 1'b1;
    tick();
    check_bit("err_clr2", err, 1'b0);
    Bank_sel    = '0;
    Bank_sel[3] = 1'b1;
    write_address_all[3*AW +: AW] = AW'(120);
    tick();
    err_clr  = 1'b0;
    Bank_sel = '0;
    check_bit("err_set_wins", err, 1'b1);

    // Reset with reads in flight (err is 1 going in)
    rd8R_en    = 1'b0;
    rdR_sel    = 4'd0;
    rd_address = AW'(0);
    tick();
    rd_address = AW'(1);
    tick();
    check_bit("pre_rst_valid", rd_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_valid", rd_valid, 1'b0);
    check_bus("mid_rst_data", rd_data, '0);
    check_bit("mid_rst_err", err, 1'b0);
    rd_address = AW'(2);
    tick();
    rd_address = AW'(3);
    tick();
    rst_n   = 1'b1;
    rd8R_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_bit("post_rst_valid", rd_valid, 1'b0);
      check_bus("post_rst_data", rd_data, '0);
      check_bit("post_rst_err", err, 1'b0);
    end

    // First edge after release accepts a read
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    do_read("first_edge", 1, 0);
    check_lane("first_edge", 1, 8'd1);

    // Random traffic against a reference model
    idle();
    tick();
    tick();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) known[b][a] = 1'b0;
    n_valid = 0;
    n_acc   = 0;
    err_m   = 1'b0;
    err_clr = 1'b1;
    tick();
    for (int c = 0; c < 10000; c++) begin
      if (rd_valid === 1'b1) n_valid++;
      take_output();
      check_bit("rand_err", err, err_m);
      Bank_sel = NB'($urandom);
      for (int i = 0; i < NB; i++) begin
        write_address_all[i*AW +: AW] = AW'($urandom_range(0, DEPTH + 3));
        wr_data[i*PW +: PW] = PW'($urandom);
      end
      rd8R_en    = 1'($urandom_range(0, 1));
      rd_address = AW'($urandom_range(0, DEPTH + 3));
      rdR_sel    = 4'($urandom_range(0, 9));
      err_clr    = ($urandom_range(0, 15) == 0);
      set        = 1'b0;
      if (!rd8R_en) begin
        n_acc++;
        e.exp  = '0;
        e.mask = '0;
        if (int'(rd_address) >= DEPTH || int'(rdR_sel) >= 8) begin
          e.mask = '1;
          set    = 1'b1;
        end else begin
          for (int j = 0; j < NB; j++) begin
            int s;
            s = (j + 4 * int'(rdR_sel)) % NB;
            if (known[s][int'(rd_address)]) begin
              e.exp[j*PW +: PW]  = mdl[s][int'(rd_address)];
              e.mask[j*PW +: PW] = '1;
            end
          end
        end
        q.push_back(e);
      end
      for (int i = 0; i < NB; i++) begin
        if (Bank_sel[i]) begin
          int a;
          a = int'(write_address_all[i*AW +: AW]);
          if (a < DEPTH) begin
            mdl[i][a]   = wr_data[i*PW +: PW];
            known[i][a] = 1'b1;
          end else begin
            set = 1'b1;
          end
        end
      end
      err_m = set | (err_m & ~err_clr);
      tick();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      if (rd_valid === 1'b1) n_valid++;
      take_output();
      tick();
    end
    check_bus("rand_queue_empty", W'(q.size()), '0);
    check_bus("rand_valid_count", W'(n_valid), W'(n_acc));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
